// File: rtl/apb_fifo_bridge_pkg.sv
// Shared constants for apb_fifo_bridge: register offsets and bit positions
// of the STATUS, CONTROL and IRQ_EN registers.
package apb_fifo_bridge_pkg;

  localparam logic [3:0] REG_DATA    = 4'h0;
  localparam logic [3:0] REG_STATUS  = 4'h4;
  localparam logic [3:0] REG_CONTROL = 4'h8;
  localparam logic [3:0] REG_IRQ_EN  = 4'hC;

  localparam int unsigned ST_TX_EMPTY   = 0;
  localparam int unsigned ST_TX_FULL    = 1;
  localparam int unsigned ST_RX_EMPTY   = 2;
  localparam int unsigned ST_RX_FULL    = 3;
  localparam int unsigned ST_TX_OVF     = 4;
  localparam int unsigned ST_RX_UNF     = 5;
  localparam int unsigned ST_TX_CNT_LSB = 8;
  localparam int unsigned ST_RX_CNT_LSB = 16;
  localparam int unsigned ST_CNT_W      = 8;

  localparam int unsigned CTRL_TX_FLUSH = 0;
  localparam int unsigned CTRL_RX_FLUSH = 1;

  localparam int unsigned IEN_RX_NONEMPTY = 0;
  localparam int unsigned IEN_TX_EMPTY    = 1;

endpackage

// File: rtl/apb_fifo_bridge_sfifo.sv
// First-word fall-through synchronous FIFO used for both bridge directions.
// Full/empty are judged on pre-edge state; flush overrides push and pop.
module apb_fifo_bridge_sfifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [PW:0]       r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push & ~o_full & ~i_flush;
  assign w_pop_ok  = i_pop & ~o_empty & ~i_flush;
  assign o_count   = r_count;
  // Head word is forced to zero when empty so stale storage never leaks out.
  assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/apb_fifo_bridge.sv
// Zero-wait APB3 slave bridging the CPU to fabric through TX and RX FIFOs.
// Optional IRQ_EN register and level interrupt: define APB_FIFO_BRIDGE_IRQ_EN.
module apb_fifo_bridge
  import apb_fifo_bridge_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              SYSCLK,
  input  logic              NSYSRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY,
  input  logic [DATA_W-1:0] RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic              IRQ
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] w_word;
  logic [3:0]        w_off;
  logic              w_in_range;
  logic              w_acc, w_wr, w_rd;
  logic              w_sel_data, w_sel_status, w_sel_control, w_sel_irq_en;
  logic              w_mapped;

  logic              w_tx_push, w_tx_pop, w_tx_flush, w_tx_full, w_tx_empty;
  logic              w_rx_push, w_rx_pop, w_rx_flush, w_rx_full, w_rx_empty;
  logic [CW-1:0]     w_tx_count, w_rx_count;
  logic [DATA_W-1:0] w_tx_rdata, w_rx_rdata;
  logic              w_tx_ovf_evt, w_rx_unf_evt;
  logic              r_tx_ovf, r_rx_unf;
  logic [31:0]       w_status;
  logic              w_unused;

`ifdef APB_FIFO_BRIDGE_IRQ_EN
  logic [1:0]        r_irq_en;
  logic              r_irq;
`endif

  // Byte address decode; the two lowest address bits are ignored.
  assign w_word     = PADDR >> 2;
  assign w_in_range = (w_word < ADDR_W'(4));
  assign w_off      = {w_word[1:0], 2'b00};

  // Gating with reset makes the APB response drop asynchronously mid-transfer.
  assign w_acc = PSEL & PENABLE & NSYSRESET;
  assign w_wr  = w_acc & PWRITE;
  assign w_rd  = w_acc & ~PWRITE;

  assign w_sel_data    = w_in_range & (w_off == REG_DATA);
  assign w_sel_status  = w_in_range & (w_off == REG_STATUS);
  assign w_sel_control = w_in_range & (w_off == REG_CONTROL);
`ifdef APB_FIFO_BRIDGE_IRQ_EN
  assign w_sel_irq_en  = w_in_range & (w_off == REG_IRQ_EN);
`else
  assign w_sel_irq_en  = 1'b0;
`endif
  assign w_mapped = w_sel_data | w_sel_status | w_sel_control | w_sel_irq_en;

  assign w_tx_ovf_evt = w_wr & w_sel_data & w_tx_full;
  assign w_tx_push    = w_wr & w_sel_data & ~w_tx_full;
  assign w_tx_pop     = TX_READY & ~w_tx_empty;
  assign w_tx_flush   = w_wr & w_sel_control & PWDATA[CTRL_TX_FLUSH];

  assign w_rx_unf_evt = w_rd & w_sel_data & w_rx_empty;
  assign w_rx_pop     = w_rd & w_sel_data & ~w_rx_empty;
  assign w_rx_push    = RX_VALID & ~w_rx_full;
  assign w_rx_flush   = w_wr & w_sel_control & PWDATA[CTRL_RX_FLUSH];

  apb_fifo_bridge_sfifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_tx_fifo (
    .i_clk   (SYSCLK),
    .i_rst_n (NSYSRESET),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_flush (w_tx_flush),
    .i_wdata (PWDATA[DATA_W-1:0]),
    .o_rdata (w_tx_rdata),
    .o_count (w_tx_count),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  apb_fifo_bridge_sfifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rx_fifo (
    .i_clk   (SYSCLK),
    .i_rst_n (NSYSRESET),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_flush (w_rx_flush),
    .i_wdata (RX_DATA),
    .o_rdata (w_rx_rdata),
    .o_count (w_rx_count),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  assign TX_DATA  = w_tx_rdata;
  assign TX_VALID = ~w_tx_empty;
  assign RX_READY = ~w_rx_full;

  // Sticky error flags; an error and its write-1-to-clear never share an access.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      r_tx_ovf <= 1'b0;
      r_rx_unf <= 1'b0;
    end else begin
      if (w_tx_ovf_evt)
        r_tx_ovf <= 1'b1;
      else if (w_wr & w_sel_status & PWDATA[ST_TX_OVF])
        r_tx_ovf <= 1'b0;
      if (w_rx_unf_evt)
        r_rx_unf <= 1'b1;
      else if (w_wr & w_sel_status & PWDATA[ST_RX_UNF])
        r_rx_unf <= 1'b0;
    end
  end

  always_comb begin
    w_status = '0;
    w_status[ST_TX_EMPTY] = w_tx_empty;
    w_status[ST_TX_FULL]  = w_tx_full;
    w_status[ST_RX_EMPTY] = w_rx_empty;
    w_status[ST_RX_FULL]  = w_rx_full;
    w_status[ST_TX_OVF]   = r_tx_ovf;
    w_status[ST_RX_UNF]   = r_rx_unf;
    w_status[ST_TX_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(w_tx_count);
    w_status[ST_RX_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(w_rx_count);
  end

  always_comb begin
    PRDATA = '0;
    if (w_rd) begin
      if (w_sel_data)
        PRDATA = 32'(w_rx_rdata);
      else if (w_sel_status)
        PRDATA = w_status;
`ifdef APB_FIFO_BRIDGE_IRQ_EN
      else if (w_sel_irq_en)
        PRDATA = 32'(r_irq_en);
`endif
    end
  end

  assign PREADY  = w_acc;
  assign PSLVERR = w_acc & (w_tx_ovf_evt | w_rx_unf_evt | ~w_mapped);

`ifdef APB_FIFO_BRIDGE_IRQ_EN
  // Interrupt is sampled from the current FIFO state, so it trails it by a cycle.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      r_irq_en <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr & w_sel_irq_en)
        r_irq_en <= {PWDATA[IEN_TX_EMPTY], PWDATA[IEN_RX_NONEMPTY]};
      r_irq <= (r_irq_en[IEN_RX_NONEMPTY] & ~w_rx_empty) |
               (r_irq_en[IEN_TX_EMPTY] & w_tx_empty);
    end
  end
  assign IRQ = r_irq;
`else
  assign IRQ = 1'b0;
`endif

  assign w_unused = ^{PWDATA, w_word};

endmodule

// File: tb/tb_apb_fifo_bridge.sv
// Self-checking bench for apb_fifo_bridge: register vector table, directed
// corner sequences and a randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_apb_fifo_bridge;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
`ifdef APB_FIFO_BRIDGE_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic              SYSCLK = 1'b0;
  logic              NSYSRESET;
  logic              PSEL, PENABLE, PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY, PSLVERR;
  logic [DATA_W-1:0] TX_DATA;
  logic              TX_VALID, TX_READY;
  logic [DATA_W-1:0] RX_DATA;
  logic              RX_VALID, RX_READY;
  logic              IRQ;

  always #5 SYSCLK = ~SYSCLK;

  apb_fifo_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .IRQ(IRQ)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic idle_inputs();
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
  endtask

  task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err);
    PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = a; PWDATA = wd;
    tick();
    PENABLE = 1;
    #1;
    chk("pready_access", 32'(PREADY), 32'd1);
    rd  = PRDATA;
    err = PSLVERR;
    tick();
    idle_inputs();
  endtask

  task automatic rd_reg(input string name, input logic [3:0] a,
                        input logic [31:0] exp, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    apb(1'b0, a, 32'd0, rd, err);
    chk({name, "_rdata"}, rd, exp);
    chk({name, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic wr_reg(input string name, input logic [3:0] a,
                        input logic [31:0] wd, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    apb(1'b1, a, wd, rd, err);
    chk({name, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic do_reset();
    NSYSRESET = 0;
    idle_inputs();
    TX_READY = 0; RX_VALID = 0; RX_DATA = '0;
    repeat (2) tick();
    NSYSRESET = 1;
    tick();
  endtask

  task automatic run_random(input int ncyc);
    int unsigned txq[$];
    int unsigned rxq[$];
    bit          m_ovf = 0, m_unf = 0, m_irq = 0;
    bit   [1:0]  m_en = 0;
    int          ph = 0;
    int          pct_tx, pct_rx, r;
    bit          acc, mapped, exp_err, tx_push, rx_pop, tx_fl, rx_fl, irq_n;
    logic [1:0]  word;
    logic [31:0] exp_rd, st;
    for (int c = 0; c < ncyc; c++) begin
      pct_tx = ((c / 500) % 2 == 0) ? 20 : 80;
      pct_rx = ((c / 500) % 2 == 0) ? 70 : 25;
      if (ph == 1) begin
        ph = 2;
        PENABLE = 1;
      end else if ($urandom_range(0, 9) < 7) begin
        ph = 1;
        r = $urandom_range(0, 99);
        word = (r < 50) ? 2'd0 : (r < 70) ? 2'd1 : (r < 80) ? 2'd2 : 2'd3;
        PSEL = 1; PENABLE = 0; PWRITE = $urandom_range(0, 1);
        PADDR = {word, 2'($urandom_range(0, 3))};
        PWDATA = $urandom;
      end else begin
        ph = 0;
        idle_inputs();
      end
      TX_READY = ($urandom_range(0, 99) < pct_tx);
      RX_VALID = ($urandom_range(0, 99) < pct_rx);
      RX_DATA  = DATA_W'($urandom);
      #1;
      acc    = PSEL && PENABLE;
      word   = PADDR[3:2];
      mapped = (word != 2'd3) || HAS_IRQ;
      exp_err = acc && ((word == 0 && PWRITE && txq.size() == DEPTH) ||
                        (word == 0 && !PWRITE && rxq.size() == 0) || !mapped);
      st = (txq.size() == 0 ? 1 : 0) + (txq.size() == DEPTH ? 2 : 0) +
           (rxq.size() == 0 ? 4 : 0) + (rxq.size() == DEPTH ? 8 : 0) +
           (m_ovf ? 16 : 0) + (m_unf ? 32 : 0) +
           txq.size() * 256 + rxq.size() * 65536;
      exp_rd = 0;
      if (acc && !PWRITE) begin
        if (word == 0 && rxq.size() > 0) exp_rd = rxq[0];
        if (word == 1) exp_rd = st;
        if (word == 3 && HAS_IRQ) exp_rd = 32'(m_en);
      end
      chk("rnd_pready", 32'(PREADY), 32'(acc));
      chk("rnd_pslverr", 32'(PSLVERR), 32'(exp_err));
      chk("rnd_prdata", PRDATA, exp_rd);
      chk("rnd_tx_valid", 32'(TX_VALID), 32'(txq.size() > 0));
      if (txq.size() > 0) chk("rnd_tx_data", 32'(TX_DATA), txq[0]);
      chk("rnd_rx_ready", 32'(RX_READY), 32'(rxq.size() < DEPTH));
      chk("rnd_irq", 32'(IRQ), 32'(m_irq));
      // Reference update for the coming edge, all decisions from pre-edge state.
      irq_n = HAS_IRQ && ((m_en[0] && rxq.size() > 0) || (m_en[1] && txq.size() == 0));
      tx_push = 0; rx_pop = 0;
      if (acc && PWRITE && word == 0) begin
        if (txq.size() < DEPTH) tx_push = 1; else m_ovf = 1;
      end
      if (acc && !PWRITE && word == 0) begin
        if (rxq.size() > 0) rx_pop = 1; else m_unf = 1;
      end
      if (acc && PWRITE && word == 1) begin
        if (PWDATA[4]) m_ovf = 0;
        if (PWDATA[5]) m_unf = 0;
      end
      if (acc && PWRITE && word == 3 && HAS_IRQ) m_en = PWDATA[1:0];
      tx_fl = acc && PWRITE && word == 2 && PWDATA[0];
      rx_fl = acc && PWRITE && word == 2 && PWDATA[1];
      if (tx_fl) txq.delete();
      else begin
        if (TX_READY && txq.size() > 0) void'(txq.pop_front());
        if (tx_push) txq.push_back(PWDATA & 32'hFF);
      end
      if (rx_fl) rxq.delete();
      else begin
        if (RX_VALID && rxq.size() < DEPTH) begin
          if (rx_pop) void'(rxq.pop_front());
          rxq.push_back(32'(RX_DATA));
        end else if (rx_pop) void'(rxq.pop_front());
      end
      m_irq = irq_n;
      tick();
    end
    idle_inputs();
    TX_READY = 0; RX_VALID = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;

    NSYSRESET = 0;
    idle_inputs();
    TX_READY = 0; RX_VALID = 0; RX_DATA = '0;
    #3;
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_pready", 32'(PREADY), 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_tx_data", 32'(TX_DATA), 32'd0);
    chk("rst_tx_valid", 32'(TX_VALID), 32'd0);
    chk("rst_rx_ready", 32'(RX_READY), 32'd1);
    chk("rst_irq", 32'(IRQ), 32'd0);
    repeat (2) tick();
    NSYSRESET = 1;
    tick();

    vecs.push_back('{"status_rst",   1'b0, 4'h4, 32'h0,  32'h0000_0005, 1'b0});
    vecs.push_back('{"wr_a5_0",      1'b1, 4'h0, 32'hA5, 32'h0,         1'b0});
    vecs.push_back('{"wr_a5_1",      1'b1, 4'h0, 32'hA5, 32'h0,         1'b0});
    vecs.push_back('{"wr_a5_2",      1'b1, 4'h0, 32'hA5, 32'h0,         1'b0});
    vecs.push_back('{"status_tx3",   1'b0, 4'h4, 32'h0,  32'h0000_0304, 1'b0});
    vecs.push_back('{"status_alias", 1'b0, 4'h5, 32'h0,  32'h0000_0304, 1'b0});
    vecs.push_back('{"control_rd",   1'b0, 4'h8, 32'h0,  32'h0,         1'b0});
    vecs.push_back('{"irq_en_rd",    1'b0, 4'hC, 32'h0,  32'h0,         !HAS_IRQ});
    foreach (vecs[i]) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      chk({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
    end
    chk("tx_valid_3", 32'(TX_VALID), 32'd1);
    chk("tx_data_3", 32'(TX_DATA), 32'hA5);

    TX_READY = 1;
    repeat (2) tick();
    chk("tx_valid_drain2", 32'(TX_VALID), 32'd1);
    tick();
    TX_READY = 0;
    chk("tx_valid_drain3", 32'(TX_VALID), 32'd0);

    for (int i = 0; i <= DEPTH; i++)
      wr_reg((i == DEPTH) ? "tx_ovf_last" : "tx_fill", 4'h0, 32'(i + 1), i == DEPTH);
    chk("tx_head_kept", 32'(TX_DATA), 32'd1);
    rd_reg("status_ovf", 4'h4, 32'h0000_1016, 1'b0);
    wr_reg("w1c_ovf", 4'h4, 32'h10, 1'b0);
    rd_reg("status_ovf_clr", 4'h4, 32'h0000_1006, 1'b0);

    // Push to a full TX while it pops in the same cycle: still rejected.
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 4'h0; PWDATA = 32'h99;
    tick();
    PENABLE = 1; TX_READY = 1;
    #1;
    chk("full_push_pop_err", 32'(PSLVERR), 32'd1);
    tick();
    TX_READY = 0;
    idle_inputs();
    rd_reg("status_full_pp", 4'h4, 32'h0000_0F14, 1'b0);
    chk("tx_head_after_pp", 32'(TX_DATA), 32'd2);
    wr_reg("w1c_ovf2", 4'h4, 32'h10, 1'b0);
    wr_reg("tx_flush", 4'h8, 32'h1, 1'b0);
    rd_reg("status_tx_flushed", 4'h4, 32'h0000_0005, 1'b0);

    RX_VALID = 1; RX_DATA = 8'h11; tick();
    RX_DATA = 8'h22; tick();
    RX_VALID = 0;
    rd_reg("rx_rd_11", 4'h0, 32'h11, 1'b0);
    rd_reg("rx_rd_22", 4'h0, 32'h22, 1'b0);
    rd_reg("rx_underflow", 4'h0, 32'h0, 1'b1);
    rd_reg("status_unf", 4'h4, 32'h0000_0025, 1'b0);
    wr_reg("w1c_unf", 4'h4, 32'h20, 1'b0);
    rd_reg("status_unf_clr", 4'h4, 32'h0000_0005, 1'b0);

    // Word pushed at the edge that opens the access phase is readable in it.
    RX_VALID = 1; RX_DATA = 8'h33;
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 4'h0;
    tick();
    RX_VALID = 0; PENABLE = 1;
    #1;
    chk("rx_latency_data", PRDATA, 32'h33);
    chk("rx_latency_err", 32'(PSLVERR), 32'd0);
    tick();
    idle_inputs();

    RX_VALID = 1;
    for (int i = 0; i < DEPTH; i++) begin
      RX_DATA = DATA_W'(8'h40 + i);
      tick();
    end
    chk("rx_ready_full", 32'(RX_READY), 32'd0);
    rd_reg("status_rx_full", 4'h4, 32'h0010_0009, 1'b0);
    wr_reg("rx_flush_full", 4'h8, 32'h2, 1'b0);
    RX_VALID = 0;
    chk("rx_ready_flushed", 32'(RX_READY), 32'd1);
    rd_reg("status_rx_flushed", 4'h4, 32'h0000_0005, 1'b0);

    RX_VALID = 1; RX_DATA = 8'h44;
    wr_reg("rx_flush_vs_push", 4'h8, 32'h2, 1'b0);
    RX_VALID = 0;
    rd_reg("status_flush_prio", 4'h4, 32'h0000_0005, 1'b0);

`ifdef APB_FIFO_BRIDGE_IRQ_EN
    wr_reg("irq_en_wr", 4'hC, 32'h1, 1'b0);
    rd_reg("irq_en_rb", 4'hC, 32'h1, 1'b0);
    chk("irq_idle", 32'(IRQ), 32'd0);
    RX_VALID = 1; RX_DATA = 8'h55;
    tick();
    RX_VALID = 0;
    chk("irq_push_n", 32'(IRQ), 32'd0);
    tick();
    chk("irq_push_n1", 32'(IRQ), 32'd1);
    rd_reg("irq_pop", 4'h0, 32'h55, 1'b0);
    chk("irq_pop_m", 32'(IRQ), 32'd1);
    tick();
    chk("irq_pop_m1", 32'(IRQ), 32'd0);
    wr_reg("irq_en_tx", 4'hC, 32'h2, 1'b0);
    tick();
    chk("irq_tx_empty", 32'(IRQ), 32'd1);
    wr_reg("irq_en_off", 4'hC, 32'h0, 1'b0);
    tick();
    chk("irq_off", 32'(IRQ), 32'd0);
`else
    RX_VALID = 1; RX_DATA = 8'h55;
    tick();
    RX_VALID = 0;
    repeat (2) tick();
    chk("irq_tied_low", 32'(IRQ), 32'd0);
    rd_reg("irq_en_unmapped_rd", 4'hC, 32'h0, 1'b1);
    wr_reg("irq_en_unmapped_wr", 4'hC, 32'h3, 1'b1);
    rd_reg("irq_drain", 4'h0, 32'h55, 1'b0);
`endif

    // Reset in the middle of an access phase.
    wr_reg("pre_rst_wr", 4'h0, 32'h5A, 1'b0);
    RX_VALID = 1; RX_DATA = 8'h66; tick(); RX_VALID = 0;
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 4'h0; PWDATA = 32'h77;
    tick();
    PENABLE = 1;
    #2;
    NSYSRESET = 0;
    #1;
    chk("midrst_pready", 32'(PREADY), 32'd0);
    chk("midrst_pslverr", 32'(PSLVERR), 32'd0);
    chk("midrst_tx_valid", 32'(TX_VALID), 32'd0);
    chk("midrst_tx_data", 32'(TX_DATA), 32'd0);
    chk("midrst_rx_ready", 32'(RX_READY), 32'd1);
    idle_inputs();
    tick();
    NSYSRESET = 1;
    tick();
    rd_reg("status_post_rst", 4'h4, 32'h0000_0005, 1'b0);

    do_reset();
    run_random(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
